// File: rtl/kernel_pr_start_fifo_mc_pkg.sv
// Shared definitions for the kernel_pr start-token FIFOs: mode codes,
// pointer reset value and the occupancy-width helper.
package kernel_pr_fifo_pkg;

    localparam int MODE_INDEP = 0;
    localparam int MODE_BCAST = 1;

    // Read pointer value meaning "empty" (-1); sliced to ADDR_WIDTH+1 bits by users.
    localparam logic [8:0] PTR_RST = '1;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/kernel_pr_start_fifo_mc_if.sv
// Producer/consumer bundle of the multi-channel start FIFO; the FIFO is the slave.
interface kernel_pr_start_fifo_mc_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2
);
    // Handshake: a write transfers on a rising edge where if_write & if_write_ce &
    // if_full_n are all high; a read transfers where if_read & if_read_ce &
    // if_empty_n are all high. if_dout is valid whenever if_empty_n is high.
    logic [NUM_CH-1:0]                if_write;
    logic [NUM_CH-1:0]                if_write_ce;
    logic [NUM_CH*DATA_WIDTH-1:0]     if_din;
    logic [NUM_CH-1:0]                if_full_n;
    logic [NUM_CH-1:0]                if_afull_n;
    logic [NUM_CH-1:0]                if_read;
    logic [NUM_CH-1:0]                if_read_ce;
    logic [NUM_CH*DATA_WIDTH-1:0]     if_dout;
    logic [NUM_CH-1:0]                if_empty_n;
    logic [NUM_CH*(ADDR_WIDTH+1)-1:0] if_count;
    logic                             err_clr;
    logic [NUM_CH-1:0]                ovf_err;
    logic [NUM_CH-1:0]                udf_err;

    modport master (
        output if_write, if_write_ce, if_din, if_read, if_read_ce, err_clr,
        input  if_full_n, if_afull_n, if_dout, if_empty_n, if_count, ovf_err, udf_err
    );

    modport slave (
        input  if_write, if_write_ce, if_din, if_read, if_read_ce, err_clr,
        output if_full_n, if_afull_n, if_dout, if_empty_n, if_count, ovf_err, udf_err
    );

endinterface

// File: rtl/kernel_pr_start_fifo_mc_ch.sv
// One start-token channel: shift-register storage addressed by a read pointer
// that sits at -1 when empty, with registered flags, occupancy and sticky errors.
module kernel_pr_start_fifo_ch
    import kernel_pr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 1,
    parameter int ADDR_WIDTH  = 2,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req,
    input  logic                  wr_full_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_req,
    input  logic                  err_clr,
    input  logic                  ovf_hit,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full_n,
    output logic                  afull_n,
    output logic                  empty_n,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rd_acc,
    output logic                  ovf_err,
    output logic                  udf_err
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] PTR_EMPTY = PTR_RST[PW-1:0];
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 2);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] ONE       = PW'(1);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [PW-1:0]         count_nxt;
    logic                  wr_acc;

    // wr_full_n is this channel's own full_n, or the combined one in broadcast.
    always_comb begin
        wr_acc  = wr_req & wr_full_n;
        rd_acc  = rd_req & empty_n;
        ptr_nxt = ptr;
        if (wr_acc && !rd_acc)
            ptr_nxt = ptr + ONE;
        else if (rd_acc && !wr_acc)
            ptr_nxt = ptr - ONE;
        count_nxt = ptr_nxt + ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= PTR_EMPTY;
            count   <= '0;
            full_n  <= 1'b1;
            afull_n <= 1'b1;
            empty_n <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            count   <= count_nxt;
            afull_n <= (count_nxt < AFULL_LVL);
            if (wr_acc && !rd_acc) begin
                empty_n <= 1'b1;
                if (ptr == PTR_LAST)
                    full_n <= 1'b0;
            end else if (rd_acc && !wr_acc) begin
                full_n <= 1'b1;
                if (ptr == '0)
                    empty_n <= 1'b0;
            end
            // A new error wins over a coincident clear.
            if (ovf_hit)
                ovf_err <= 1'b1;
            else if (err_clr)
                ovf_err <= 1'b0;
            if (rd_req && !empty_n)
                udf_err <= 1'b1;
            else if (err_clr)
                udf_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            srl[0] <= din;
            for (int k = 1; k < DEPTH; k++)
                srl[k] <= srl[k-1];
        end
    end

    assign dout = ptr[PW-1] ? srl[0] : srl[ptr[PW-2:0]];

endmodule

// File: rtl/kernel_pr_start_fifo_mc.sv
// Multi-channel start-token FIFO: per-channel instances plus the broadcast
// write fan-out, combined full/almost-full and vector packing.
module kernel_pr_start_fifo_mc
    import kernel_pr_fifo_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DATA_WIDTH  = 1,
    parameter int ADDR_WIDTH  = 2,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3,
    parameter int BROADCAST   = 0
) (
    input logic                     clk,
    input logic                     reset_n,
    kernel_pr_start_fifo_mc_if.slave bus
);
    localparam bit IS_BCAST = (BROADCAST == MODE_BCAST);
    localparam int CW       = ADDR_WIDTH + 1;
    localparam int DW       = DATA_WIDTH;

    logic [NUM_CH-1:0]    wr_req;
    logic [NUM_CH-1:0]    wr_full_n;
    logic [NUM_CH-1:0]    rd_req;
    logic [NUM_CH-1:0]    rd_acc;
    logic [NUM_CH-1:0]    ovf_hit;
    logic [NUM_CH-1:0]    full_n_ch;
    logic [NUM_CH-1:0]    afull_n_ch;
    logic [NUM_CH-1:0]    empty_n_ch;
    logic [NUM_CH-1:0]    ovf_ch;
    logic [NUM_CH-1:0]    udf_ch;
    logic [NUM_CH*DW-1:0] din_v;
    logic [NUM_CH*DW-1:0] dout_v;
    logic [NUM_CH*CW-1:0] count_v;
    logic                 bc_wr;
    logic                 full_all;
    logic                 afull_all;
    logic                 bc_excused;

    assign bc_wr     = bus.if_write[0] & bus.if_write_ce[0];
    assign full_all  = &full_n_ch;
    assign afull_all = &afull_n_ch;
    // A blocked broadcast write is not an overflow when every full channel reads that cycle.
    assign bc_excused = &(rd_acc | full_n_ch);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_req[i]    = IS_BCAST ? bc_wr : (bus.if_write[i] & bus.if_write_ce[i]);
        assign wr_full_n[i] = IS_BCAST ? full_all : full_n_ch[i];
        assign rd_req[i]    = bus.if_read[i] & bus.if_read_ce[i];
        assign din_v[i*DW +: DW] = IS_BCAST ? bus.if_din[DW-1:0] : bus.if_din[i*DW +: DW];
        assign ovf_hit[i]   = IS_BCAST ? (bc_wr & ~full_all & ~bc_excused)
                                       : (wr_req[i] & ~full_n_ch[i] & ~rd_acc[i]);

        kernel_pr_start_fifo_ch #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .DEPTH       (DEPTH),
            .AFULL_LEVEL (AFULL_LEVEL)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_req    (wr_req[i]),
            .wr_full_n (wr_full_n[i]),
            .din       (din_v[i*DW +: DW]),
            .rd_req    (rd_req[i]),
            .err_clr   (bus.err_clr),
            .ovf_hit   (ovf_hit[i]),
            .dout      (dout_v[i*DW +: DW]),
            .full_n    (full_n_ch[i]),
            .afull_n   (afull_n_ch[i]),
            .empty_n   (empty_n_ch[i]),
            .count     (count_v[i*CW +: CW]),
            .rd_acc    (rd_acc[i]),
            .ovf_err   (ovf_ch[i]),
            .udf_err   (udf_ch[i])
        );
    end

    assign bus.if_full_n  = IS_BCAST ? {NUM_CH{full_all}}  : full_n_ch;
    assign bus.if_afull_n = IS_BCAST ? {NUM_CH{afull_all}} : afull_n_ch;
    assign bus.if_empty_n = empty_n_ch;
    assign bus.if_dout    = dout_v;
    assign bus.if_count   = count_v;
    assign bus.ovf_err    = ovf_ch;
    assign bus.udf_err    = udf_ch;

endmodule

// File: tb/tb_kernel_pr_start_fifo_mc.sv
// Directed bench: an independent-mode FIFO (2 ch) driven from a vector table,
// and a broadcast-mode FIFO (3 ch) exercised by hand-written sequences.
module tb_kernel_pr_start_fifo_mc;
    import kernel_pr_fifo_pkg::*;

    localparam int CW = cnt_w(4);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    kernel_pr_start_fifo_mc_if #(.NUM_CH(2), .DATA_WIDTH(1), .ADDR_WIDTH(2)) bus_a ();
    kernel_pr_start_fifo_mc_if #(.NUM_CH(3), .DATA_WIDTH(1), .ADDR_WIDTH(2)) bus_b ();

    kernel_pr_start_fifo_mc #(
        .NUM_CH(2), .DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_LEVEL(3), .BROADCAST(0)
    ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

    kernel_pr_start_fifo_mc #(
        .NUM_CH(3), .DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_LEVEL(3), .BROADCAST(1)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr, wce, din, rd, clr;
        logic [2:0] cnt;
        logic       fn, afn, en, dv, dout, ovf, udf;
    } vec_t;

    localparam int NV = 35;
    vec_t tv [NV];

    function automatic vec_t mk(input logic wr, wce, din, rd, clr, input int cnt,
                                input logic fn, afn, en, dv, dout, ovf, udf);
        vec_t v;
        v.wr = wr; v.wce = wce; v.din = din; v.rd = rd; v.clr = clr;
        v.cnt = 3'(cnt);
        v.fn = fn; v.afn = afn; v.en = en; v.dv = dv; v.dout = dout; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.if_write = '0; bus_a.if_write_ce = '0; bus_a.if_din = '0;
        bus_a.if_read  = '0; bus_a.if_read_ce  = '0; bus_a.err_clr = 1'b0;
        bus_b.if_write = '0; bus_b.if_write_ce = '0; bus_b.if_din = '0;
        bus_b.if_read  = '0; bus_b.if_read_ce  = '0; bus_b.err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] tok [4];
        logic [8:0] exp_cnt_b;
        tok[0] = 3'd1; tok[1] = 3'd0; tok[2] = 3'd1; tok[3] = 3'd1;

        // fill, drain, underflow, simultaneous r/w, full corner cases, overflow
        tv[0]  = mk(1,0,1,0,0, 0,1,1,0,0,0,0,0);
        tv[1]  = mk(1,1,1,0,0, 1,1,1,1,1,1,0,0);
        tv[2]  = mk(1,1,0,0,0, 2,1,1,1,1,1,0,0);
        tv[3]  = mk(1,1,1,0,0, 3,1,0,1,1,1,0,0);
        tv[4]  = mk(1,1,1,0,0, 4,0,0,1,1,1,0,0);
        tv[5]  = mk(0,0,0,1,0, 3,1,0,1,1,0,0,0);
        tv[6]  = mk(0,0,0,1,0, 2,1,1,1,1,1,0,0);
        tv[7]  = mk(0,0,0,1,0, 1,1,1,1,1,1,0,0);
        tv[8]  = mk(0,0,0,1,0, 0,1,1,0,0,0,0,0);
        tv[9]  = mk(0,0,0,1,0, 0,1,1,0,0,0,0,1);
        tv[10] = mk(1,1,1,1,0, 1,1,1,1,1,1,0,1);
        tv[11] = mk(0,0,0,0,1, 1,1,1,1,1,1,0,0);
        tv[12] = mk(1,1,1,0,0, 2,1,1,1,1,1,0,0);
        tv[13] = mk(1,1,0,1,0, 2,1,1,1,1,1,0,0);
        tv[14] = mk(1,1,1,1,0, 2,1,1,1,1,0,0,0);
        tv[15] = mk(1,1,1,1,0, 2,1,1,1,1,1,0,0);
        tv[16] = mk(1,1,0,1,0, 2,1,1,1,1,1,0,0);
        tv[17] = mk(1,1,1,1,0, 2,1,1,1,1,0,0,0);
        tv[18] = mk(1,1,0,1,0, 2,1,1,1,1,1,0,0);
        tv[19] = mk(1,1,0,1,0, 2,1,1,1,1,0,0,0);
        tv[20] = mk(1,1,1,1,0, 2,1,1,1,1,0,0,0);
        tv[21] = mk(1,1,1,1,0, 2,1,1,1,1,1,0,0);
        tv[22] = mk(1,1,0,1,0, 2,1,1,1,1,1,0,0);
        tv[23] = mk(1,1,1,0,0, 3,1,0,1,1,1,0,0);
        tv[24] = mk(1,1,0,0,0, 4,0,0,1,1,1,0,0);
        tv[25] = mk(1,1,1,1,0, 3,1,0,1,1,0,0,0);
        tv[26] = mk(1,1,1,0,0, 4,0,0,1,1,0,0,0);
        tv[27] = mk(1,1,0,0,0, 4,0,0,1,1,0,1,0);
        tv[28] = mk(0,0,0,0,0, 4,0,0,1,1,0,1,0);
        tv[29] = mk(1,1,0,0,1, 4,0,0,1,1,0,1,0);
        tv[30] = mk(0,0,0,0,1, 4,0,0,1,1,0,0,0);
        tv[31] = mk(0,0,0,1,0, 3,1,0,1,1,1,0,0);
        tv[32] = mk(0,0,0,1,0, 2,1,1,1,1,0,0,0);
        tv[33] = mk(0,0,0,1,0, 1,1,1,1,1,1,0,0);
        tv[34] = mk(0,0,0,1,0, 0,1,1,0,0,0,0,0);

        // clock/reset
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst a count",   32'(bus_a.if_count), 0);
        chk("rst a empty_n", 32'(bus_a.if_empty_n), 0);
        chk("rst a full_n",  32'(bus_a.if_full_n), 32'h3);
        chk("rst a afull_n", 32'(bus_a.if_afull_n), 32'h3);
        chk("rst a ovf",     32'(bus_a.ovf_err), 0);
        chk("rst a udf",     32'(bus_a.udf_err), 0);
        chk("rst b count",   32'(bus_b.if_count), 0);
        chk("rst b full_n",  32'(bus_b.if_full_n), 32'h7);

        // independent mode, channel 0 from the table; channel 1 must stay idle
        for (int v = 0; v < NV; v++) begin
            bus_a.if_write    = {1'b0, tv[v].wr};
            bus_a.if_write_ce = {1'b0, tv[v].wce};
            bus_a.if_din      = {1'b0, tv[v].din};
            bus_a.if_read     = {1'b0, tv[v].rd};
            bus_a.if_read_ce  = {1'b0, tv[v].rd};
            bus_a.err_clr     = tv[v].clr;
            step();
            chk($sformatf("v%0d count", v),   32'(bus_a.if_count[CW-1:0]), 32'(tv[v].cnt));
            chk($sformatf("v%0d full_n", v),  32'(bus_a.if_full_n[0]), 32'(tv[v].fn));
            chk($sformatf("v%0d afull_n", v), 32'(bus_a.if_afull_n[0]), 32'(tv[v].afn));
            chk($sformatf("v%0d empty_n", v), 32'(bus_a.if_empty_n[0]), 32'(tv[v].en));
            chk($sformatf("v%0d ovf", v),     32'(bus_a.ovf_err[0]), 32'(tv[v].ovf));
            chk($sformatf("v%0d udf", v),     32'(bus_a.udf_err[0]), 32'(tv[v].udf));
            if (tv[v].dv)
                chk($sformatf("v%0d dout", v), 32'(bus_a.if_dout[0]), 32'(tv[v].dout));
            chk($sformatf("v%0d ch1 count", v), 32'(bus_a.if_count[2*CW-1:CW]), 0);
        end
        idle_inputs();

        // broadcast: writes on the other channels' ports are ignored
        bus_b.if_write = 3'b110; bus_b.if_write_ce = 3'b110; bus_b.if_din = 3'b110;
        step();
        chk("bc ignored wr count", 32'(bus_b.if_count), 0);

        for (int k = 0; k < 4; k++) begin
            bus_b.if_write    = {2'($urandom_range(0, 3)), 1'b1};
            bus_b.if_write_ce = 3'b111;
            bus_b.if_din      = {2'($urandom_range(0, 3)), tok[k][0]};
            step();
            exp_cnt_b = {3{3'(k + 1)}};
            chk($sformatf("bc fill%0d count", k),   32'(bus_b.if_count), 32'(exp_cnt_b));
            chk($sformatf("bc fill%0d full_n", k),  32'(bus_b.if_full_n), (k == 3) ? 0 : 32'h7);
            chk($sformatf("bc fill%0d afull_n", k), 32'(bus_b.if_afull_n), (k >= 2) ? 0 : 32'h7);
            chk($sformatf("bc fill%0d dout", k),    32'(bus_b.if_dout), 32'h7);
        end
        idle_inputs();

        // drain channels 0 and 1; channel 2 stays full so combined full_n holds low
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bc ch0 tok%0d", k), 32'(bus_b.if_dout[0]), 32'(tok[k]));
            chk($sformatf("bc ch1 tok%0d", k), 32'(bus_b.if_dout[1]), 32'(tok[k]));
            bus_b.if_read = 3'b011; bus_b.if_read_ce = 3'b011;
            step();
            chk($sformatf("bc drain%0d full_n", k), 32'(bus_b.if_full_n), 0);
        end
        idle_inputs();
        chk("bc drained count", 32'(bus_b.if_count), 32'({3'd4, 3'd0, 3'd0}));
        chk("bc drained empty_n", 32'(bus_b.if_empty_n), 32'h4);

        // broadcast write while one channel is full is refused and flags everyone
        bus_b.if_write = 3'b001; bus_b.if_write_ce = 3'b001; bus_b.if_din = 3'b000;
        step();
        idle_inputs();
        chk("bc ovf all", 32'(bus_b.ovf_err), 32'h7);
        chk("bc ovf count", 32'(bus_b.if_count), 32'({3'd4, 3'd0, 3'd0}));
        bus_b.err_clr = 1'b1;
        step();
        idle_inputs();
        chk("bc ovf clr", 32'(bus_b.ovf_err), 0);

        // slow drain of channel 2
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bc ch2 tok%0d", k), 32'(bus_b.if_dout[2]), 32'(tok[k]));
            bus_b.if_read = 3'b100; bus_b.if_read_ce = 3'b100;
            step();
            idle_inputs();
            chk($sformatf("bc ch2 rd%0d full_n", k), 32'(bus_b.if_full_n), 32'h7);
            chk($sformatf("bc ch2 rd%0d afull_n", k), 32'(bus_b.if_afull_n), (k == 0) ? 0 : 32'h7);
            step();
            chk($sformatf("bc ch2 rd%0d count", k), 32'(bus_b.if_count[8:6]), 32'(3 - k));
        end
        chk("bc end empty_n", 32'(bus_b.if_empty_n), 0);
        chk("bc end udf", 32'(bus_b.udf_err), 0);

        // asynchronous reset in the middle of a write burst
        bus_a.if_write = 2'b11; bus_a.if_write_ce = 2'b11; bus_a.if_din = 2'b01;
        for (int k = 0; k < 3; k++) step();
        chk("burst count", 32'(bus_a.if_count), 32'({3'd3, 3'd3}));
        #3;
        reset_n = 1'b0;
        #1;
        chk("async rst count",   32'(bus_a.if_count), 0);
        chk("async rst empty_n", 32'(bus_a.if_empty_n), 0);
        chk("async rst full_n",  32'(bus_a.if_full_n), 32'h3);
        chk("async rst afull_n", 32'(bus_a.if_afull_n), 32'h3);
        idle_inputs();
        step();
        reset_n = 1'b1;
        step();
        chk("post rst count", 32'(bus_a.if_count), 0);
        bus_a.if_write = 2'b01; bus_a.if_write_ce = 2'b01; bus_a.if_din = 2'b01;
        step();
        idle_inputs();
        chk("post rst wr count", 32'(bus_a.if_count), 32'd1);
        chk("post rst wr dout",  32'(bus_a.if_dout[0]), 32'd1);
        chk("post rst wr empty_n", 32'(bus_a.if_empty_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
